// File: rtl/sr_drv_pkg.sv
// Shared definitions for the SR latch driver: command op encodings and the FSM state type.
package sr_drv_pkg;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_SET = 2'b01;
    localparam logic [1:0] OP_RST = 2'b10;
    localparam logic [1:0] OP_TGL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

endpackage

// File: rtl/sr_pulse_timer.sv
// Loadable down-counter shared by the PULSE and GUARD phases; done is high while the count is zero.
module sr_pulse_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// Command-side driver for the SR latch cell: turns set/reset/toggle commands into registered
// S or R pulses with a dead-time guard, then checks the latch readback.
module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int PULSE_W = 2,
    parameter int GUARD_W = 1,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    output logic       cmd_ready,
    output logic       S,
    output logic       R,
    output logic       C,
    input  logic       Q_fb,
    input  logic       Q_n_fb,
    output logic       exp_q,
    output logic       busy,
    output logic       fault,
    input  logic       fault_clr
);

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_W - 1);

    state_t           state_q, state_d;
    logic             tgt_q, tgt_d;
    logic             expQ_q, expQ_d;
    logic             fault_q, fault_d;
    logic             sDrive_q, sDrive_d;
    logic             rDrive_q, rDrive_d;
    logic             busy_q, busy_d;
    logic             cmdReady_q, cmdReady_d;
    logic             faultSet;
    logic             tmrLoad;
    logic             tmrEn;
    logic             tmrDone;
    logic [CNT_W-1:0] tmrVal;

    sr_pulse_timer #(
        .CNT_W(CNT_W)
    ) uTimer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmrLoad),
        .en      (tmrEn),
        .load_val(tmrVal),
        .done    (tmrDone)
    );

    assign tmrEn = (state_q != ST_IDLE);

    // Outputs are computed from the next state so S/R/C/busy/cmd_ready come straight off flops.
    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        expQ_d   = expQ_q;
        faultSet = 1'b0;
        tmrLoad  = 1'b0;
        tmrVal   = PULSE_LOAD;

        case (state_q)
            ST_IDLE: begin
                if (Q_fb == Q_n_fb) faultSet = 1'b1;
                if (cmd_valid && cmdReady_q) begin
                    case (cmd_op)
                        OP_NOP: ;
                        OP_SET: begin
                            tgt_d   = 1'b1;
                            state_d = ST_PULSE;
                            tmrLoad = 1'b1;
                        end
                        OP_RST: begin
                            tgt_d   = 1'b0;
                            state_d = ST_PULSE;
                            tmrLoad = 1'b1;
                        end
                        OP_TGL: begin
                            tgt_d   = ~expQ_q;
                            state_d = ST_PULSE;
                            tmrLoad = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_PULSE: begin
                if (tmrDone) begin
                    state_d = ST_GUARD;
                    tmrLoad = 1'b1;
                    tmrVal  = GUARD_LOAD;
                end
            end
            ST_GUARD: begin
                if (Q_fb == Q_n_fb) faultSet = 1'b1;
                if (tmrDone) begin
                    state_d = ST_IDLE;
                    expQ_d  = tgt_q;
                    if ((Q_fb != tgt_q) || (Q_n_fb != ~tgt_q)) faultSet = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        fault_d    = faultSet ? 1'b1 : (fault_clr ? 1'b0 : fault_q);
        sDrive_d   = (state_d == ST_PULSE) && tgt_d;
        rDrive_d   = (state_d == ST_PULSE) && !tgt_d;
        busy_d     = (state_d != ST_IDLE);
        cmdReady_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tgt_q      <= 1'b0;
            expQ_q     <= 1'b0;
            fault_q    <= 1'b0;
            sDrive_q   <= 1'b0;
            rDrive_q   <= 1'b0;
            busy_q     <= 1'b0;
            cmdReady_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            expQ_q     <= expQ_d;
            fault_q    <= fault_d;
            sDrive_q   <= sDrive_d;
            rDrive_q   <= rDrive_d;
            busy_q     <= busy_d;
            cmdReady_q <= cmdReady_d;
        end
    end

    assign S         = sDrive_q;
    assign R         = rDrive_q;
    assign C         = sDrive_q | rDrive_q;
    assign busy      = busy_q;
    assign cmd_ready = cmdReady_q;
    assign exp_q     = expQ_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Self-checking bench for sr_latch_driver: directed literal checks, then randomized commands,
// latch faults and resets compared every cycle against a cycle-index schedule model.
module tb_sr_latch_driver;
    import sr_drv_pkg::*;

    localparam int P = 2;
    localparam int G = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = OP_NOP;
    logic       fault_clr = 1'b0;
    logic       forceIllegal = 1'b0;
    logic       stuckLow = 1'b0;
    logic       latchQ = 1'b0;
    logic       Q_fb, Q_n_fb;
    logic       cmd_ready, S, R, C, exp_q, busy, fault;

    int  tests = 0;
    int  failed = 0;
    bit  checkEn = 1'b0;

    int  cyc = 0;
    bit  mActive = 1'b0;
    int  mAcc = 0;
    bit  mTgt = 1'b0;
    bit  mExpQ = 1'b0;
    bit  mFault = 1'b0;
    bit  mReady = 1'b0;

    sr_latch_driver #(
        .PULSE_W(P),
        .GUARD_W(G),
        .CNT_W  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_op   (cmd_op),
        .cmd_ready(cmd_ready),
        .S        (S),
        .R        (R),
        .C        (C),
        .Q_fb     (Q_fb),
        .Q_n_fb   (Q_n_fb),
        .exp_q    (exp_q),
        .busy     (busy),
        .fault    (fault),
        .fault_clr(fault_clr)
    );

    always #5 clk = ~clk;

    // Latch cell model, optionally stuck low or forced into the illegal Q == Q_n state.
    always @(negedge clk) latchQ <= S ? 1'b1 : (R ? 1'b0 : latchQ);
    assign Q_fb   = forceIllegal ? 1'b1 : (stuckLow ? 1'b0 : latchQ);
    assign Q_n_fb = forceIllegal ? 1'b1 : ~(stuckLow ? 1'b0 : latchQ);

    // Schedule model: a command accepted at the edge that starts cycle a pulses in cycles
    // a..a+P-1, guards in a+P..a+P+G-1 and completes at the edge ending that last guard cycle.
    always @(posedge clk) begin
        bit inPulse, inGuard, setF;
        inPulse = mActive && (cyc >= mAcc) && (cyc < mAcc + P);
        inGuard = mActive && (cyc >= mAcc + P) && (cyc < mAcc + P + G);
        if (rst) begin
            mActive = 1'b0;
            mExpQ   = 1'b0;
            mFault  = 1'b0;
            mReady  = 1'b0;
        end else begin
            setF = !inPulse && (Q_fb == Q_n_fb);
            if (inGuard && (cyc == mAcc + P + G - 1)) begin
                if ((Q_fb != mTgt) || (Q_n_fb != !mTgt)) setF = 1'b1;
                mExpQ   = mTgt;
                mActive = 1'b0;
            end else if (!mActive && mReady && cmd_valid && (cmd_op != 2'b00)) begin
                mActive = 1'b1;
                mAcc    = cyc + 1;
                mTgt    = (cmd_op == 2'b01) ? 1'b1 : (cmd_op == 2'b10) ? 1'b0 : !mExpQ;
            end
            if (setF) mFault = 1'b1;
            else if (fault_clr) mFault = 1'b0;
            mReady = !mActive;
        end
        cyc++;
    end

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s at cycle %0d: got %b, expected %b", name, cyc, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic [1:0] op,
                                 input logic clr, input logic ill, input logic stuck);
        @(negedge clk);
        rst          = r;
        cmd_valid    = v;
        cmd_op       = op;
        fault_clr    = clr;
        forceIllegal = ill;
        stuckLow     = stuck;
    endtask

    // Per-cycle comparison of every output against the model, plus the S/R exclusivity check.
    always @(negedge clk) begin
        if (checkEn) begin
            bit eS, eR;
            eS = mActive && mTgt && (cyc >= mAcc) && (cyc < mAcc + P);
            eR = mActive && !mTgt && (cyc >= mAcc) && (cyc < mAcc + P);
            checkOutput("S", S, eS);
            checkOutput("R", R, eR);
            checkOutput("C", C, eS | eR);
            checkOutput("busy", busy, mActive);
            checkOutput("cmd_ready", cmd_ready, mReady);
            checkOutput("exp_q", exp_q, mExpQ);
            checkOutput("fault", fault, mFault);
            checkOutput("SRoverlap", S & R, 1'b0);
            assert (!(S && R)) else $error("[TB] FAIL S and R high together at cycle %0d", cyc);
        end
    end

    initial begin
        applyStimulus(1, 0, OP_NOP, 0, 0, 0);
        applyStimulus(1, 0, OP_NOP, 0, 0, 0);
        applyStimulus(1, 0, OP_NOP, 0, 0, 0);
        checkOutput("rst_ready", cmd_ready, 1'b0);
        checkOutput("rst_S", S, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_fault", fault, 1'b0);
        checkOutput("rst_expq", exp_q, 1'b0);
        checkEn = 1'b1;

        // Set command held until accepted, then the fixed pulse/guard timeline.
        applyStimulus(0, 1, OP_SET, 0, 0, 0);
        applyStimulus(0, 1, OP_SET, 0, 0, 0);
        checkOutput("lit_ready_after_rst", cmd_ready, 1'b1);
        applyStimulus(0, 0, OP_NOP, 0, 0, 0);
        checkOutput("lit_S_c1", S, 1'b1);
        checkOutput("lit_C_c1", C, 1'b1);
        checkOutput("lit_R_c1", R, 1'b0);
        checkOutput("lit_ready_c1", cmd_ready, 1'b0);
        applyStimulus(0, 0, OP_NOP, 0, 0, 0);
        checkOutput("lit_S_c2", S, 1'b1);
        applyStimulus(0, 0, OP_NOP, 0, 0, 0);
        checkOutput("lit_S_guard", S, 1'b0);
        checkOutput("lit_busy_guard", busy, 1'b1);
        applyStimulus(0, 0, OP_NOP, 0, 1, 0);
        checkOutput("lit_ready_done", cmd_ready, 1'b1);
        checkOutput("lit_expq_done", exp_q, 1'b1);
        checkOutput("lit_fault_done", fault, 1'b0);

        // Illegal readback in IDLE sets fault; fault_clr loses to a concurrent error.
        applyStimulus(0, 0, OP_NOP, 1, 1, 0);
        checkOutput("lit_fault_illegal", fault, 1'b1);
        applyStimulus(0, 0, OP_NOP, 1, 0, 0);
        checkOutput("lit_fault_clr_loses", fault, 1'b1);
        applyStimulus(0, 0, OP_NOP, 0, 0, 0);
        checkOutput("lit_fault_cleared", fault, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            logic r, v, clr, ill, stuck;
            logic [1:0] op;
            r     = ($urandom_range(0, 63) == 0);
            v     = ($urandom_range(0, 1) == 1);
            op    = 2'($urandom_range(0, 3));
            clr   = ($urandom_range(0, 7) == 0);
            ill   = ($urandom_range(0, 39) == 0);
            stuck = ($urandom_range(0, 15) == 0);
            applyStimulus(r, v, op, clr, ill, stuck);
        end

        applyStimulus(0, 0, OP_NOP, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/sr_latch_driver.md
# sr_latch_driver

Synchronous command-side driver for the team's set/reset latch cell. Accepts set/reset/toggle commands over a valid/ready handshake and turns each into a registered, fixed-width S or R pulse followed by a dead-time guard, so S and R are never both driven. Reads back the latch's Q/Q_n at the end of each command and raises a sticky fault on mismatch or on the illegal Q == Q_n condition. Sits between control logic in the clock domain and the latch's S/R/C pins.

## Interface
- PULSE_W, 2: cycles S or R is held high per command; legal range 1..2^CNT_W-1.
- GUARD_W, 1: dead cycles with S = R = 0 after each pulse; legal range 1..2^CNT_W-1.
- CNT_W, 4: width of the internal pulse/guard counter.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_op  in  2  00 nop, 01 set, 10 reset, 11 toggle.
- cmd_ready  out  1  driver can accept a command this cycle.
- S  out  1  set drive to latch.
- R  out  1  reset drive to latch.
- C  out  1  latch enable; high exactly while S or R is high.
- Q_fb  in  1  latch Q readback.
- Q_n_fb  in  1  latch Q_n readback.
- exp_q  out  1  expected latch state after the last completed command.
- busy  out  1  high in PULSE and GUARD.
- fault  out  1  sticky readback fault.
- fault_clr  in  1  clears fault.

## Operation
- FSM states: IDLE, PULSE, GUARD.
- IDLE: cmd_ready = 1. On cmd_valid & cmd_ready:
  - nop: consumed, no pulse, stay IDLE.
  - set / reset: latch the target; go to PULSE.
  - toggle: resolves to set if exp_q == 0, otherwise reset.
- PULSE: drive S (set) or R (reset) plus C for PULSE_W cycles; counter loads PULSE_W-1, counts down to 0, then go to GUARD.
- GUARD: S = R = C = 0 for GUARD_W cycles. On the last GUARD cycle:
  - sample Q_fb / Q_n_fb;
  - exp_q updates to the target;
  - fault sets if Q_fb != target or Q_n_fb != ~target.
  - Return to IDLE.
- Continuous monitor, IDLE and GUARD: Q_fb == Q_n_fb sets fault. Not checked in PULSE, where the latch is in transition.
- fault_clr clears fault on the next edge. A set condition in the same cycle wins over fault_clr.
- S and R are never high in the same cycle under any input sequence. This invariant must be asserted in verification.

## Timing
- All outputs are registered. No combinational path from any input to S, R or C.
- Reset values: S = R = C = 0, busy = 0, fault = 0, exp_q = 0, FSM = IDLE. cmd_ready = 0 while rst is high and 1 in the first cycle after it drops.
- Command accepted at edge t:
  - S/R/C high in cycles t+1 .. t+PULSE_W;
  - guard in cycles t+PULSE_W+1 .. t+PULSE_W+GUARD_W;
  - exp_q and fault update at the edge ending the last guard cycle;
  - cmd_ready high again in cycle t+PULSE_W+GUARD_W+1.
- Command period is PULSE_W+GUARD_W+1 cycles. A nop occupies one cycle.
- cmd_valid while cmd_ready = 0 is ignored, not queued. The initiator must hold the command until the handshake completes.
- rst mid-PULSE or mid-GUARD: S/R/C fall at that edge, the command is abandoned, and exp_q returns to 0.
- No readback mismatch is checked after reset until a command completes. The illegal-state monitor is active immediately.

## Structure
- Shared package sr_drv_pkg holds:
  - the op encoding constants (OP_NOP, OP_SET, OP_RST, OP_TGL);
  - the FSM state typedef.
- One sub-module, sr_pulse_timer: a loadable CNT_W-bit down-counter with load, en, and a done flag when the count is 0. It is instantiated once and reused for the PULSE and GUARD phases.

## Test plan
- Reset, then set with PULSE_W=2, GUARD_W=1 and a latch model attached -> S high for exactly 2 cycles, R stays 0, cmd_ready returns at t+4, exp_q = 1, fault = 0.
- Toggle issued 3 times from exp_q = 0 -> pulses are S, R, S; exp_q goes 1, 0, 1; S and R never overlap.
- Latch model forced to hold Q = 0 during a set command -> fault = 1 after the last guard cycle. fault_clr held with no new error -> fault = 0 on the next edge.
- Q_fb = Q_n_fb = 1 while IDLE -> fault sets on the next edge. Same condition plus fault_clr in the same cycle -> fault stays 1.
- rst asserted in the 2nd PULSE cycle of a set -> S = 0 at the next edge, exp_q = 0, cmd_ready = 1 after rst drops.
- Back-to-back cmd_valid with nop, set, reset -> nop consumed in 1 cycle; set accepted next cycle; reset held until cmd_ready returns and then accepted.
